// File: rtl/dtc_pkg.sv
// Shared types and sizing helpers for the sequential decision-tree evaluator.
package dtc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WALK,
      DONE
   } dtc_state_e;

   localparam logic CFG_SEL_NODE = 1'b0;
   localparam logic CFG_SEL_LEAF = 1'b1;

   function automatic int n_nodes(input int depth);
      return (1 << depth) - 1;
   endfunction

   function automatic int n_leaves(input int depth);
      return 1 << depth;
   endfunction

endpackage

// File: rtl/dtc_tree_table.sv
// Register tables for a complete binary tree: feature index per internal node,
// class label per leaf, one write port and two combinational read ports.
module dtc_tree_table
   import dtc_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int CLS_W  = 1,
   parameter int FIDX_W = 4,
   parameter int CFG_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              sel,
   input  logic [DEPTH-1:0]  addr,
   input  logic [CFG_W-1:0]  data,
   input  logic [DEPTH-1:0]  node_addr,
   output logic [FIDX_W-1:0] node_feat,
   input  logic [DEPTH-1:0]  leaf_addr,
   output logic [CLS_W-1:0]  leaf_class
);

   localparam int NODES  = n_nodes(DEPTH);
   localparam int LEAVES = n_leaves(DEPTH);

   // The node array has one spare top entry so every DEPTH-bit address is in
   // range; it is never written and always reads as feature 0.
   logic [FIDX_W-1:0] feat [LEAVES];
   logic [CLS_W-1:0]  leaf [LEAVES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LEAVES; i++) begin
            feat[i] <= '0;
            leaf[i] <= '0;
         end
      end else if (we) begin
         if (sel == CFG_SEL_NODE) begin
            if (int'(addr) < NODES) begin
               feat[addr] <= data[FIDX_W-1:0];
            end
         end else begin
            leaf[addr] <= data[CLS_W-1:0];
         end
      end
   end

   assign node_feat  = feat[node_addr];
   assign leaf_class = leaf[leaf_addr];

endmodule

// File: rtl/dtc_seq_eval.sv
// Runtime-programmable decision-tree classifier that walks one tree level per
// clock, with valid/ready handshakes on the sample and result sides.
module dtc_seq_eval
   import dtc_pkg::*;
#(
   parameter int N_INPUTS = 10,
   parameter int DEPTH    = 4,
   parameter int CLS_W    = 1,
   parameter int FIDX_W   = $clog2(N_INPUTS),
   parameter int CFG_W    = (FIDX_W > CLS_W) ? FIDX_W : CLS_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N_INPUTS-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CLS_W-1:0]    out_class,
   input  logic                cfg_we,
   input  logic                cfg_sel,
   input  logic [DEPTH-1:0]    cfg_addr,
   input  logic [CFG_W-1:0]    cfg_data,
   output logic                cfg_ready
);

   localparam int NODES = n_nodes(DEPTH);
   localparam int IW    = DEPTH + 1;
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int EXT_W = 1 << FIDX_W;

   dtc_state_e          state;
   logic [N_INPUTS-1:0] sample_q;
   logic [IW-1:0]       node_idx;
   logic [IW-1:0]       child_idx;
   logic [LVL_W-1:0]    level;
   logic [FIDX_W-1:0]   feat_sel;
   logic [CLS_W-1:0]    leaf_class;
   logic [EXT_W-1:0]    sample_ext;
   logic [DEPTH-1:0]    leaf_idx;
   logic                bit_sel;

   // Zero-extending the sample makes any feature index >= N_INPUTS read as 0.
   always_comb begin
      sample_ext                 = '0;
      sample_ext[N_INPUTS-1:0]   = sample_q;
      bit_sel                    = sample_ext[feat_sel];
      child_idx                  = (node_idx << 1) + IW'(1) + IW'(bit_sel);
      leaf_idx                   = DEPTH'(child_idx - IW'(NODES));
   end

   dtc_tree_table #(
      .DEPTH  (DEPTH),
      .CLS_W  (CLS_W),
      .FIDX_W (FIDX_W),
      .CFG_W  (CFG_W)
   ) u_table (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (cfg_we & cfg_ready),
      .sel        (cfg_sel),
      .addr       (cfg_addr),
      .data       (cfg_data),
      .node_addr  (node_idx[DEPTH-1:0]),
      .node_feat  (feat_sel),
      .leaf_addr  (leaf_idx),
      .leaf_class (leaf_class)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         cfg_ready <= 1'b1;
         out_valid <= 1'b0;
         out_class <= '0;
         sample_q  <= '0;
         node_idx  <= '0;
         level     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sample_q  <= in_data;
                  node_idx  <= '0;
                  level     <= '0;
                  in_ready  <= 1'b0;
                  cfg_ready <= 1'b0;
                  state     <= WALK;
               end
            end
            WALK: begin
               node_idx <= child_idx;
               level    <= level + LVL_W'(1);
               if (level == LVL_W'(DEPTH - 1)) begin
                  out_class <= leaf_class;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  cfg_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               cfg_ready <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/dtc_seq_eval.md
Name: dtc_seq_eval

Overview:
- Parametrised, runtime-programmable decision-tree classifier. It replaces the fixed, hard-wired combinational tree blocks (one module per trained tree) with a single reusable evaluator.
- The tree is a complete binary tree of depth DEPTH held in a register table. It is loaded through a config port.
- One feature sample is classified per transaction, walking one tree level per clock, with valid/ready on both the input and output sides.

Parameters:
- N_INPUTS, 10, number of binary features in a sample.
- DEPTH, 4, number of tree levels. There are 2^DEPTH-1 internal nodes and 2^DEPTH leaves. Legal range 1..8.
- CLS_W, 1, width of a class label.
- FIDX_W, $clog2(N_INPUTS), width of a feature index.
- CFG_W, max(FIDX_W, CLS_W), width of the config data bus.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  evaluator can accept a sample
- in_data  in  N_INPUTS  feature vector
- out_valid  out  1  classification result valid
- out_ready  in  1  downstream accepts result
- out_class  out  CLS_W  classification result
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = internal-node table, 1 = leaf table
- cfg_addr  in  DEPTH  node index (0..2^DEPTH-2) or leaf index (0..2^DEPTH-1)
- cfg_data  in  CFG_W  node: feature index in [FIDX_W-1:0]; leaf: class in [CLS_W-1:0]
- cfg_ready  out  1  high when a config write is accepted (IDLE only)

Behaviour:
- Clock and reset:
  - Single clock domain on clk.
  - rst_n is asynchronous assert, active-low.
  - Reset drives: state = IDLE, in_ready = 1, out_valid = 0, out_class = 0, cfg_ready = 1, level counter = 0, all node feature indices = 0, all leaf classes = 0.
- State IDLE:
  - in_ready = 1 and cfg_ready = 1.
  - in_valid & in_ready at an edge: latch in_data into sample_q, set node_idx = 0 and level = 0, go to WALK.
- State WALK:
  - in_ready = 0 and cfg_ready = 0.
  - Each cycle: b = sample_q[feat[node_idx]]; node_idx <= 2*node_idx + 1 + b; level <= level + 1.
  - When level == DEPTH-1, the edge updating node_idx also loads out_class <= leaf[(2*node_idx+1+b) - (2^DEPTH-1)] and sets out_valid = 1, then go to DONE.
  - Latency: out_valid rises on the DEPTH-th edge after the accepting edge.
- State DONE:
  - out_valid = 1; out_class is held stable until out_valid & out_ready.
  - On that handshake edge: out_valid = 0, go to IDLE.
  - No bypass: a new sample is accepted at the earliest on the edge after the result handshake.
  - Throughput is therefore one result per DEPTH+2 cycles with out_ready tied high.
- Index arithmetic:
  - node_idx is DEPTH+1 bits wide so that the child computation never overflows.
  - A feature index >= N_INPUTS selects bit value 0.
- Config writes:
  - Take effect only when cfg_we & cfg_ready.
  - Writes in WALK or DONE are dropped silently, so the table cannot change mid-evaluation.
  - A node write with cfg_addr > 2^DEPTH-2 is ignored.
- Simultaneous cfg_we and in_valid in IDLE:
  - Both are accepted.
  - The sample is evaluated with the table including this write, because the write lands on the same edge as the sample is latched and the first lookup happens in the next cycle.
- Reset mid-operation: any state returns to IDLE immediately, the in-flight result is lost, and the tables return to the reset values.
- in_data is sampled only on the accepting edge; later changes do not affect the result.

Decomposition:
- Shared package dtc_pkg holds:
  - state enum dtc_state_e {IDLE, WALK, DONE};
  - localparam functions n_nodes(DEPTH) = 2^DEPTH-1 and n_leaves(DEPTH) = 2^DEPTH;
  - constant CFG_SEL_NODE = 0 and CFG_SEL_LEAF = 1.
- One natural sub-module, dtc_tree_table: node and leaf register arrays, write port, and two combinational read ports (feature at node_idx, class at leaf index).
- The FSM, counter and handshake logic stay in dtc_seq_eval.

Test Plan:
- Tree setup for all cases: DEPTH=2, N_INPUTS=10, CLS_W=1. Program nodes {0:feat1, 1:feat3, 2:feat2} and leaves {0:1, 1:0, 2:0, 3:1}.
- in_data = 10'h000 -> out_class = 1; out_valid rises exactly 2 edges after accept.
- in_data = 10'h006 (bits 1 and 2 set) -> out_class = 1, via leaf 3.
- in_data = 10'h002 -> out_class = 0, via leaf 2; in_data = 10'h008 -> out_class = 0, via leaf 1.
- Hold out_ready = 0 for 5 cycles in DONE -> out_valid and out_class are stable and in_ready = 0; raise out_ready -> IDLE next edge.
- Write leaf 0 := 0 while in WALK -> the write is dropped, and a repeat of 10'h000 still gives 1. The same write in IDLE together with in_valid -> 0.
- Assert rst_n = 0 mid-WALK -> out_valid = 0 and in_ready = 1 immediately. After release, an unprogrammed tree gives out_class = 0 for any input.
